// File: rtl/fetch_sequencer_if.sv
// ============================================================================
// Module  : fetch_sequencer_if
// Purpose : Instruction-memory, redirect and decode-side signals of the fetch sequencer
// Revision: 1.0
// ============================================================================
`default_nettype none

interface fetch_sequencer_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        stall;
  logic        inst_valid;
  logic [31:0] inst_pc;
  logic [31:0] inst_data;
  logic        discard_pending;

  modport master (
    output imem_req, imem_addr, inst_valid, inst_pc, inst_data, discard_pending,
    input  imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_target, stall
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst_pc, inst_data, discard_pending,
    output imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_target, stall
  );
endinterface

`default_nettype wire

// File: rtl/fetch_sequencer.sv
// ============================================================================
// Module  : fetch_sequencer
// Purpose : PC owner; one-at-a-time instruction fetch with redirect/squash
// Revision: 1.0
// ============================================================================
`default_nettype none

module fetch_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] INST_BYTES   = 32'd4
) (
  input  logic               clk,
  input  logic               rst,
  fetch_sequencer_if.master  bus
);

  localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_OUT  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        discard_q, discard_d;
  logic        inst_valid_q, inst_valid_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic [31:0] inst_data_q, inst_data_d;
  logic [31:0] redirect_pc;

  assign redirect_pc = bus.redirect_target & ALIGN_MASK;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_VECTOR & ALIGN_MASK;
      discard_q    <= 1'b0;
      inst_valid_q <= 1'b0;
      inst_pc_q    <= 32'h0;
      inst_data_q  <= 32'h0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      discard_q    <= discard_d;
      inst_valid_q <= inst_valid_d;
      inst_pc_q    <= inst_pc_d;
      inst_data_q  <= inst_data_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    discard_d    = discard_q;
    inst_valid_d = inst_valid_q;
    inst_pc_d    = inst_pc_q;
    inst_data_d  = inst_data_q;

    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (bus.imem_gnt) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus.imem_rvalid) begin
          if (discard_q) begin
            discard_d = 1'b0;
            state_d   = S_REQ;
          end else begin
            inst_data_d  = bus.imem_rdata;
            inst_pc_d    = pc_q;
            inst_valid_d = 1'b1;
            pc_d         = pc_q + INST_BYTES;
            state_d      = S_OUT;
          end
        end
      end
      S_OUT: begin
        if (!bus.stall) begin
          inst_valid_d = 1'b0;
          state_d      = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A redirect overrides everything above, including a response that lands this cycle.
    if (bus.redirect_valid) begin
      pc_d         = redirect_pc;
      inst_valid_d = 1'b0;
      inst_pc_d    = inst_pc_q;
      inst_data_d  = inst_data_q;
      case (state_q)
        S_REQ: begin
          if (bus.imem_gnt) begin
            discard_d = 1'b1;
            state_d   = S_WAIT;
          end else begin
            state_d   = S_IDLE;
          end
        end
        S_WAIT: begin
          if (bus.imem_rvalid) begin
            discard_d = 1'b0;
            state_d   = S_REQ;
          end else begin
            discard_d = 1'b1;
            state_d   = S_WAIT;
          end
        end
        default: state_d = S_REQ;
      endcase
    end
  end

  // Address comes straight from pc, so it can only move when a redirect has dropped the request.
  assign bus.imem_req        = (state_q == S_REQ);
  assign bus.imem_addr       = pc_q & ALIGN_MASK;
  assign bus.inst_valid      = inst_valid_q;
  assign bus.inst_pc         = inst_pc_q;
  assign bus.inst_data       = inst_data_q;
  assign bus.discard_pending = discard_q;

endmodule

`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
// ============================================================================
// Module  : tb_fetch_sequencer
// Purpose : Directed scoreboard bench for fetch_sequencer
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_fetch_sequencer;

  localparam logic [31:0] RV = 32'hFFFF_FFFC;

  logic clk = 1'b0;
  logic rst;

  fetch_sequencer_if bus0 ();
  fetch_sequencer_if bus1 ();

  fetch_sequencer #(.RESET_VECTOR(RV), .INST_BYTES(32'd4)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  fetch_sequencer dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  always #5 clk = ~clk;

  int          total  = 0;
  int          passed = 0;
  logic [63:0] sb_q[$];
  logic        prev_valid = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Each rising edge of inst_valid is one delivery; it must match the oldest expected fetch.
  always @(negedge clk) begin
    if (rst) begin
      prev_valid <= 1'b0;
    end else begin
      if (bus0.inst_valid && !prev_valid) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_delivery", 32'(sb_q.size()), 32'd1);
        end else begin
          logic [63:0] e;
          e = sb_q.pop_front();
          chk("deliv_pc", bus0.inst_pc, e[63:32]);
          chk("deliv_data", bus0.inst_data, e[31:0]);
        end
      end
      prev_valid <= bus0.inst_valid;
    end
  end

  task automatic wait_req(input string tag);
    int n;
    n = 0;
    while (bus0.imem_req !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    if (bus0.imem_req !== 1'b1) chk({tag, "_req_timeout"}, {31'b0, bus0.imem_req}, 32'd1);
  endtask

  task automatic fetch(input logic [31:0] exp_pc, input int gnt_delay, input string tag);
    wait_req(tag);
    chk({tag, "_addr"}, bus0.imem_addr, exp_pc);
    for (int i = 0; i < gnt_delay; i++) begin
      step();
      chk({tag, "_req_held"}, {31'b0, bus0.imem_req}, 32'd1);
      chk({tag, "_addr_held"}, bus0.imem_addr, exp_pc);
    end
    bus0.imem_gnt = 1'b1;
    step();
    bus0.imem_gnt = 1'b0;
    chk({tag, "_req_drop"}, {31'b0, bus0.imem_req}, 32'd0);
    bus0.imem_rvalid = 1'b1;
    bus0.imem_rdata  = mem_word(bus0.imem_addr);
    sb_q.push_back({exp_pc, mem_word(exp_pc)});
    step();
    bus0.imem_rvalid = 1'b0;
    bus0.imem_rdata  = 32'hDEAD_BEEF;
    chk({tag, "_latency"}, {31'b0, bus0.inst_valid}, 32'd1);
  endtask

  task automatic junk_response(input string tag);
    bus0.imem_rvalid = 1'b1;
    bus0.imem_rdata  = 32'hBAD0_0BAD;
    step();
    bus0.imem_rvalid = 1'b0;
    chk({tag, "_no_valid"}, {31'b0, bus0.inst_valid}, 32'd0);
    chk({tag, "_discard_clr"}, {31'b0, bus0.discard_pending}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    bus0.imem_gnt = 1'b0; bus0.imem_rvalid = 1'b0; bus0.imem_rdata = 32'h0;
    bus0.redirect_valid = 1'b0; bus0.redirect_target = 32'h0; bus0.stall = 1'b0;
    bus1.imem_gnt = 1'b0; bus1.imem_rvalid = 1'b0; bus1.imem_rdata = 32'h0;
    bus1.redirect_valid = 1'b0; bus1.redirect_target = 32'h0; bus1.stall = 1'b0;
    step();
    step();

    chk("rst_req", {31'b0, bus0.imem_req}, 32'd0);
    chk("rst_addr", bus0.imem_addr, RV);
    chk("rst_valid", {31'b0, bus0.inst_valid}, 32'd0);
    chk("rst_pc", bus0.inst_pc, 32'h0);
    chk("rst_data", bus0.inst_data, 32'h0);
    chk("rst_discard", {31'b0, bus0.discard_pending}, 32'd0);
    chk("rst_addr_default", bus1.imem_addr, 32'h0);
    rst = 1'b0;

    // Default-parameter instance: first fetch comes from address 0.
    step();
    chk("dflt_req", {31'b0, bus1.imem_req}, 32'd1);
    chk("dflt_addr", bus1.imem_addr, 32'h0);
    bus1.imem_gnt = 1'b1;
    step();
    bus1.imem_gnt = 1'b0;
    bus1.imem_rvalid = 1'b1;
    bus1.imem_rdata  = mem_word(32'h0);
    step();
    bus1.imem_rvalid = 1'b0;
    chk("dflt_valid", {31'b0, bus1.inst_valid}, 32'd1);
    chk("dflt_pc", bus1.inst_pc, 32'h0);
    chk("dflt_data", bus1.inst_data, mem_word(32'h0));

    // Free run from the top of memory, wrapping to 0, 3-cycle period.
    fetch(RV, 0, "run0");
    step(); chk("period0", {31'b0, bus0.imem_req}, 32'd1);
    fetch(32'h0, 0, "run1");
    step(); chk("period1", {31'b0, bus0.imem_req}, 32'd1);
    fetch(32'h4, 0, "run2");
    step(); chk("period2", {31'b0, bus0.imem_req}, 32'd1);
    fetch(32'h8, 0, "run3");

    // Grant withheld for 3 cycles.
    fetch(32'hC, 3, "gnt_hold");

    // Decode stall holds the instruction and blocks new requests.
    bus0.stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("stall_valid", {31'b0, bus0.inst_valid}, 32'd1);
      chk("stall_pc", bus0.inst_pc, 32'hC);
      chk("stall_data", bus0.inst_data, mem_word(32'hC));
      chk("stall_req", {31'b0, bus0.imem_req}, 32'd0);
    end
    bus0.stall = 1'b0;
    step();
    chk("unstall_valid", {31'b0, bus0.inst_valid}, 32'd0);
    chk("unstall_req", {31'b0, bus0.imem_req}, 32'd1);
    fetch(32'h10, 0, "after_stall");

    // Redirect while waiting for the response.
    wait_req("rw");
    bus0.imem_gnt = 1'b1;
    step();
    bus0.imem_gnt = 1'b0;
    bus0.redirect_valid = 1'b1; bus0.redirect_target = 32'h0000_0103;
    step();
    bus0.redirect_valid = 1'b0;
    chk("rw_discard", {31'b0, bus0.discard_pending}, 32'd1);
    chk("rw_req", {31'b0, bus0.imem_req}, 32'd0);
    junk_response("rw");
    chk("rw_next_addr", bus0.imem_addr, 32'h0000_0100);
    fetch(32'h100, 0, "rw_target");

    // Redirect in the grant cycle.
    wait_req("rg");
    bus0.imem_gnt = 1'b1;
    bus0.redirect_valid = 1'b1; bus0.redirect_target = 32'h0000_0202;
    step();
    bus0.imem_gnt = 1'b0;
    bus0.redirect_valid = 1'b0;
    chk("rg_discard", {31'b0, bus0.discard_pending}, 32'd1);
    junk_response("rg");
    fetch(32'h200, 0, "rg_target");

    // Redirect in the response cycle.
    wait_req("rv");
    bus0.imem_gnt = 1'b1;
    step();
    bus0.imem_gnt = 1'b0;
    bus0.imem_rvalid = 1'b1; bus0.imem_rdata = 32'hBAD0_0BAD;
    bus0.redirect_valid = 1'b1; bus0.redirect_target = 32'h0000_0301;
    step();
    bus0.imem_rvalid = 1'b0;
    bus0.redirect_valid = 1'b0;
    chk("rv_no_valid", {31'b0, bus0.inst_valid}, 32'd0);
    chk("rv_discard", {31'b0, bus0.discard_pending}, 32'd0);
    fetch(32'h300, 0, "rv_target");

    // Redirect in REQ without a grant drops the request for a cycle.
    wait_req("rq");
    chk("rq_addr_before", bus0.imem_addr, 32'h304);
    bus0.redirect_valid = 1'b1; bus0.redirect_target = 32'h0000_0400;
    step();
    bus0.redirect_valid = 1'b0;
    chk("rq_req_drop", {31'b0, bus0.imem_req}, 32'd0);
    chk("rq_addr", bus0.imem_addr, 32'h400);
    fetch(32'h400, 0, "rq_target");

    // Redirect squashes the instruction sitting in OUT.
    bus0.redirect_valid = 1'b1; bus0.redirect_target = 32'h0000_0500;
    step();
    bus0.redirect_valid = 1'b0;
    chk("ro_squash", {31'b0, bus0.inst_valid}, 32'd0);
    chk("ro_req", {31'b0, bus0.imem_req}, 32'd1);
    fetch(32'h500, 0, "ro_target");

    // Two redirects while one response is outstanding: only one drop.
    wait_req("r2");
    bus0.imem_gnt = 1'b1;
    step();
    bus0.imem_gnt = 1'b0;
    bus0.redirect_valid = 1'b1; bus0.redirect_target = 32'h0000_0600;
    step();
    bus0.redirect_target = 32'h0000_0700;
    step();
    bus0.redirect_valid = 1'b0;
    chk("r2_discard", {31'b0, bus0.discard_pending}, 32'd1);
    chk("r2_addr", bus0.imem_addr, 32'h700);
    junk_response("r2");
    fetch(32'h700, 0, "r2_target");

    // Reset while a fetch is in flight.
    wait_req("rs");
    bus0.imem_gnt = 1'b1;
    step();
    bus0.imem_gnt = 1'b0;
    rst = 1'b1;
    step();
    chk("rs_req", {31'b0, bus0.imem_req}, 32'd0);
    chk("rs_addr", bus0.imem_addr, RV);
    chk("rs_valid", {31'b0, bus0.inst_valid}, 32'd0);
    chk("rs_pc", bus0.inst_pc, 32'h0);
    chk("rs_data", bus0.inst_data, 32'h0);
    chk("rs_discard", {31'b0, bus0.discard_pending}, 32'd0);
    rst = 1'b0;
    fetch(RV, 0, "rs_restart");

    step();
    step();
    chk("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Owns the architectural PC register and sequences instruction fetch from an instruction memory with a request/grant/response handshake.
- Delivers one instruction at a time, tagged with its PC, to decode.
- Applies branch/jump redirects from execute, including redirects that arrive while a fetch is in flight.
- Sits between the PC-update datapath and the instruction memory.

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
- INST_BYTES, 4, PC increment per sequential fetch.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- imem_req  output  1  fetch request to instruction memory.
- imem_addr  output  32  fetch address; bits [1:0] always 0.
- imem_gnt  input  1  memory accepts the request this cycle.
- imem_rvalid  input  1  read data valid.
- imem_rdata  input  32  instruction word.
- redirect_valid  input  1  branch/jump taken this cycle.
- redirect_target  input  32  new PC; bits [1:0] are ignored and forced to 0.
- stall  input  1  decode cannot accept the instruction this cycle.
- inst_valid  output  1  inst_data/inst_pc are valid.
- inst_pc  output  32  PC of the delivered instruction.
- inst_data  output  32  delivered instruction.
- discard_pending  output  1  an in-flight response will be dropped (debug/verification visibility).

Behaviour:
- One clock domain (clk); reset is synchronous and active-high on rst.
- Reset (including mid-operation):
  - state=IDLE, pc=RESET_VECTOR, discard=0.
  - imem_req=0, imem_addr=RESET_VECTOR, inst_valid=0, inst_pc=0, inst_data=0.
  - Memory shares rst, so no stale response follows reset.
- States:
  - IDLE: imem_req=0; next cycle goes to REQ.
  - REQ: imem_req=1, imem_addr=pc. imem_addr is held stable while imem_req=1 and imem_gnt=0. On imem_gnt, go to WAIT.
  - WAIT: imem_req=0. On imem_rvalid with discard=0: inst_data<=imem_rdata, inst_pc<=pc, inst_valid<=1, pc<=pc+INST_BYTES (mod 2^32; 32'hFFFF_FFFC wraps to 0), go to OUT. On imem_rvalid with discard=1: clear discard, go to REQ.
  - OUT: inst_valid=1, outputs held. If stall=0, inst_valid<=0 and go to REQ. If stall=1, stay in OUT, outputs unchanged.
- Latency: with gnt in the REQ cycle and rvalid one cycle later, inst_valid rises 2 cycles after REQ entry. Minimum fetch period is 3 cycles.
- Redirect has priority over every other event in the same cycle:
  - Always: pc<=redirect_target & ~3, inst_valid<=0.
  - From IDLE or OUT: go to REQ (the OUT instruction is squashed even if stall=0).
  - From REQ with imem_gnt=0: go to IDLE. The request drops for one cycle, so the address changes only while imem_req=0.
  - From REQ with imem_gnt=1: go to WAIT, discard<=1.
  - From WAIT with imem_rvalid=0: stay in WAIT, discard<=1.
  - From WAIT with imem_rvalid=1: data dropped, discard<=0, go to REQ.
  - A second redirect while discard=1 only updates pc; discard stays 1 because there is only one response to drop.
- imem_gnt outside REQ and imem_rvalid outside WAIT are ignored.
- At most one outstanding request at any time.
- discard_pending = discard register.

Test Plan:
- Reset then free-run, gnt same cycle as req, rvalid 1 cycle later, stall=0 -> inst_pc sequence 0,4,8,12 with a 3-cycle period; imem_addr matches each request.
- Hold imem_gnt=0 for 3 cycles in REQ -> imem_req stays 1 and imem_addr stays constant; fetch completes after gnt.
- stall=1 for 4 cycles while inst_valid=1 -> inst_valid, inst_pc and inst_data unchanged; no new imem_req until stall=0.
- Redirect to 32'h0000_0103 in WAIT before rvalid -> discard_pending=1; next rvalid produces no inst_valid; next imem_addr=32'h0000_0100; delivered inst_pc=32'h100.
- Redirect in the same cycle as imem_gnt, and separately in the same cycle as imem_rvalid -> the in-flight data is never delivered; next fetch is from the target.
- RESET_VECTOR=32'hFFFF_FFFC -> first inst_pc=32'hFFFF_FFFC, next imem_addr=0. Assert rst in WAIT -> IDLE, all outputs return to reset values.
